// File: rtl/hkspi_stream_master.sv
// SPI master for the housekeeping SPI port: one CSB frame carries a command
// byte, an address byte and cmd_len data bytes, SPI mode 0, MSB first.
module hkspi_stream_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 32,
    parameter int CSB_GAP   = 2,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [7:0]       wdata,
    output logic             rdata_valid,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             csb,
    output logic             sck,
    output logic             sdi,
    input  logic             sdo,
    output logic [2:0]       dbg_state
);

    localparam int GAP_CYC = CSB_GAP * CLK_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC) + 1;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       tx_q, tx_d;
    logic [6:0]       rx_q, rx_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             sck_q, sck_d;
    logic             csb_q, csb_d;
    logic             need_q, need_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic             wr_op, rd_op;

    assign wr_op = op_q[0];
    assign rd_op = op_q[1];

    // Handshakes: a transfer happens on a rising clock where valid and ready
    // are both high. cmd_ready is high in IDLE except on the done cycle;
    // wdata_ready is high only on the cycle a waiting write byte is taken.
    assign cmd_ready   = (state_q == S_IDLE) && !done_q;
    assign wdata_ready = (state_q == S_DATA) && need_q && wr_op && wdata_valid;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign csb         = csb_q;
    assign sck         = sck_q;
    assign sdi         = tx_q[7];
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        gap_d    = gap_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        op_d     = op_q;
        addr_d   = addr_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        sck_d    = sck_q;
        csb_d    = csb_q;
        need_d   = need_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == 2'b00 || cmd_len > LEN_MAX) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        csb_d   = 1'b0;
                        gap_d   = '0;
                        op_d    = cmd_op;
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        // op bits map straight onto the command byte: 01->80, 10->40, 11->C0
                        tx_d    = {cmd_op[0], cmd_op[1], 6'b0};
                    end
                end
            end
            S_SETUP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_CMD;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (state_q == S_DATA && need_q) begin
                    // Byte load point; a write with no wdata stalls here with sck low
                    if (!wr_op) begin
                        tx_d   = '0;
                        need_d = 1'b0;
                    end else if (wdata_valid) begin
                        tx_d   = wdata;
                        need_d = 1'b0;
                    end
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[5:0], sdo};
                        if (state_q == S_DATA && rd_op && bit_q == 3'd7) begin
                            rdata_d  = {rx_q, sdo};
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        sck_d = 1'b0;
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (state_q == S_CMD) begin
                                state_d = S_ADDR;
                                tx_d    = addr_q;
                            end else if (state_q == S_ADDR && len_q != '0) begin
                                state_d = S_DATA;
                                need_d  = 1'b1;
                                cnt_d   = '0;
                            end else if (state_q == S_DATA && (cnt_q + LEN_ONE) != len_q) begin
                                cnt_d  = cnt_q + LEN_ONE;
                                need_d = 1'b1;
                            end else begin
                                state_d = S_HOLD;
                                gap_d   = '0;
                                tx_d    = '0;
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            sck_q    <= 1'b0;
            csb_q    <= 1'b1;
            need_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            sck_q    <= sck_d;
            csb_q    <= csb_d;
            need_q   <= need_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_hkspi_stream_master.sv
// Directed bench for hkspi_stream_master against a behavioural hkspi slave
// holding a small register file.
module tb_hkspi_stream_master;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       csb;
    logic       sck;
    logic       sdi;
    logic       sdo;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;

    logic [7:0] t3 [19] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                            8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         done_cnt = 0;

    // slave state, owned by the slave process
    logic [7:0] mem [256];
    logic [7:0] s_sh, s_cmd, s_addr, s_out, rd_ptr, wr_ptr;
    int         s_cnt, s_frames;
    logic       last_sck, last_csb;

    hkspi_stream_master dut (
        .clock(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .busy(busy), .done(done), .err(err),
        .csb(csb), .sck(sck), .sdi(sdi), .sdo(sdo),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // hkspi slave: samples sdi on rising sck, shifts sdo on falling sck
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 19; i++) mem[i] = t3[i];
        mem[8'h20] = 8'ha5;
        mem[8'h21] = 8'h3c;
        last_sck = 1'b0; last_csb = 1'b1;
        s_cnt = 0; s_frames = 0; sdo = 1'b0;
        s_sh = '0; s_cmd = '0; s_addr = '0; s_out = '0; rd_ptr = '0; wr_ptr = '0;
        forever begin
            @(sck or csb);
            if (csb === 1'b0 && last_csb !== 1'b0) begin
                s_cnt = 0;
                s_frames++;
                sdo = 1'b0;
            end else if (csb === 1'b0 && sck === 1'b1 && last_sck !== 1'b1) begin
                s_cnt++;
                s_sh = {s_sh[6:0], sdi};
                if (s_cnt == 8) s_cmd = s_sh;
                else if (s_cnt == 16) begin
                    s_addr = s_sh; rd_ptr = s_sh; wr_ptr = s_sh;
                end else if (s_cnt > 16 && s_cnt % 8 == 0 && s_cmd[7]) begin
                    mem[wr_ptr] = s_sh;
                    wr_ptr++;
                end
            end else if (csb === 1'b0 && sck === 1'b0 && last_sck === 1'b1) begin
                if (s_cnt >= 16 && s_cmd[6]) begin
                    if (s_cnt % 8 == 0) begin
                        s_out = mem[rd_ptr];
                        rd_ptr++;
                    end
                    sdo = s_out[7];
                    s_out = {s_out[6:0], 1'b0};
                end
            end
            last_sck = sck;
            last_csb = csb;
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) got_q.push_back(rdata);
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start_cmd(input logic [1:0] op, input logic [7:0] a, input logic [5:0] n);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        wdata_valid = 1'b1;
        wdata = b;
        #1;
        while (wdata_ready !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        check("wdata_taken", {31'b0, wdata_ready}, 32'd1);
        @(negedge clk);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        while (s_cnt < n && k < 3000) begin @(negedge clk); k++; end
        check("sck_rises_reached", {31'b0, s_cnt >= n}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int k = 0;
        while (done !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, "_csb_at_done"}, {31'b0, csb}, 32'd1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'b0, cmd_ready}, 32'd1);
    endtask

    // scoreboard: compare bytes received since base against exp_q
    task automatic check_rd(input string tag, input int base);
        logic [31:0] obs;
        check({tag, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base + i < got_q.size()) ? {24'b0, got_q[base + i]} : 32'hffff_ffff;
            check(tag, obs, {24'b0, exp_q[i]});
        end
    endtask

    initial begin
        int base;
        int frames0;
        int bad;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_len = 6'd0;
        wdata_valid = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_csb", {31'b0, csb}, 32'd1);
        check("rst_sck", {31'b0, sck}, 32'd0);
        check("rst_sdi", {31'b0, sdi}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        check("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
        check("rst_rdata", {24'b0, rdata}, 32'h00);
        reset = 1'b0;
        @(negedge clk);

        // 1: read one byte at 0x03
        base = got_q.size();
        exp_q.delete(); exp_q.push_back(8'h11);
        start_cmd(2'b10, 8'h03, 6'd1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("t1_csb_low", {31'b0, csb}, 32'd0);
        check("t1_sdi_cmd_msb", {31'b0, sdi}, 32'd0);
        wait_done("t1", 1'b0);
        check("t1_cmd_byte", {24'b0, s_cmd}, 32'h40);
        check("t1_addr_byte", {24'b0, s_addr}, 32'h03);
        check("t1_rises", s_cnt, 32'd24);
        check_rd("t1_rdata", base);

        // 2: two write frames to 0x0b
        start_cmd(2'b01, 8'h0b, 6'd1);
        send_byte(8'h01);
        wait_done("t2a", 1'b0);
        check("t2a_cmd_byte", {24'b0, s_cmd}, 32'h80);
        check("t2a_mem", {24'b0, mem[8'h0b]}, 32'h01);
        check("t2a_rises", s_cnt, 32'd24);
        start_cmd(2'b01, 8'h0b, 6'd1);
        send_byte(8'h00);
        wait_done("t2b", 1'b0);
        check("t2b_mem", {24'b0, mem[8'h0b]}, 32'h00);
        check("t2b_rises", s_cnt, 32'd24);

        // 3: 19-byte read stream from 0x00
        base = got_q.size();
        exp_q.delete();
        for (int i = 0; i < 19; i++) exp_q.push_back(t3[i]);
        start_cmd(2'b10, 8'h00, 6'd19);
        wait_done("t3", 1'b0);
        check("t3_rises", s_cnt, 32'd168);
        check_rd("t3_rdata", base);

        // 4: write with a stall before the second data byte
        start_cmd(2'b01, 8'h30, 6'd3);
        send_byte(8'hde);
        wait_rises(24);
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sck !== 1'b0 || csb !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t4_stall_lines", bad, 32'd0);
        check("t4_stall_rises", s_cnt, 32'd24);
        check("t4_stall_busy", {31'b0, busy}, 32'd1);
        send_byte(8'had);
        send_byte(8'hbe);
        wait_done("t4", 1'b0);
        check("t4_rises", s_cnt, 32'd40);
        check("t4_mem0", {24'b0, mem[8'h30]}, 32'hde);
        check("t4_mem1", {24'b0, mem[8'h31]}, 32'had);
        check("t4_mem2", {24'b0, mem[8'h32]}, 32'hbe);

        // rd/wr stream: old contents come back, new contents land
        base = got_q.size();
        exp_q.delete(); exp_q.push_back(8'ha5); exp_q.push_back(8'h3c);
        start_cmd(2'b11, 8'h20, 6'd2);
        send_byte(8'h5a);
        send_byte(8'hc3);
        wait_done("rw", 1'b0);
        check("rw_cmd_byte", {24'b0, s_cmd}, 32'hc0);
        check_rd("rw_rdata", base);
        check("rw_mem0", {24'b0, mem[8'h20]}, 32'h5a);
        check("rw_mem1", {24'b0, mem[8'h21]}, 32'hc3);

        // 5: reset during the address byte
        start_cmd(2'b10, 8'h03, 6'd1);
        wait_rises(11);
        reset = 1'b1;
        @(negedge clk);
        check("t5_csb", {31'b0, csb}, 32'd1);
        check("t5_sck", {31'b0, sck}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_done", done_cnt, 32'd6);
        base = got_q.size();
        exp_q.delete(); exp_q.push_back(8'h11);
        start_cmd(2'b10, 8'h03, 6'd1);
        wait_done("t5b", 1'b0);
        check_rd("t5b_rdata", base);

        // 6: illegal op and over-length request
        frames0 = s_frames;
        start_cmd(2'b00, 8'h55, 6'd1);
        check("t6a_done", {31'b0, done}, 32'd1);
        check("t6a_err", {31'b0, err}, 32'd1);
        @(negedge clk);
        check("t6a_done_1cyc", {31'b0, done}, 32'd0);
        check("t6a_err_1cyc", {31'b0, err}, 32'd0);
        start_cmd(2'b10, 8'h00, 6'd33);
        check("t6b_done", {31'b0, done}, 32'd1);
        check("t6b_err", {31'b0, err}, 32'd1);
        repeat (5) @(negedge clk);
        check("t6_csb_high", {31'b0, csb}, 32'd1);
        check("t6_no_frame", s_frames - frames0, 32'd0);
        check("total_done", done_cnt, 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
